// File: rtl/mode7_span_stepper_pkg.sv
// Shared types and constants for the Mode-7 span stepper.
package mode7_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_SUM    = 3'd2,
    ST_STRIDE = 3'd3,
    ST_READY  = 3'd4,
    ST_RUN    = 3'd5
  } mode7_state_e;

  localparam int STRIDE_SHIFT = 16;

  function automatic int coord_w(input int map_bits, input int tex_bits, input int frac_bits);
    return map_bits + tex_bits + frac_bits + 2;
  endfunction

endpackage

// File: rtl/mode7_span_stepper_mul.sv
// One MSB-first shift-add multiplier lane: acc = delta * weight after NBITS steps.
module mode7_serial_mul #(
  parameter int W     = 29,
  parameter int NBITS = 17
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic signed [W-1:0] delta,
  input  logic [NBITS-1:0]    weight,
  output logic signed [W-1:0] acc,
  output logic                done
);
  localparam int CW = $clog2(NBITS + 1);
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  logic signed [W-1:0] r_acc;
  logic [NBITS-1:0]    r_w;
  logic [CW-1:0]       r_cnt;
  logic                r_run;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
      r_w   <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (start) begin
      r_acc <= '0;
      r_w   <= weight;
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_acc <= (r_acc <<< 1) + (r_w[NBITS-1] ? delta : '0);
      r_w   <= r_w << 1;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == LAST) r_run <= 1'b0;
    end
  end

  // High during the final step, so the product is complete on the next cycle.
  assign done = r_run && (r_cnt == LAST);
  assign acc  = r_acc;

endmodule

// File: rtl/mode7_span_stepper.sv
// Mode-7 per-scanline (u,v) generator driving map/texel ROM indices.
// Optional MODE7_CLAMP_EN: out-of-map coordinates raise outside and force indices to 0.
module mode7_span_stepper
  import mode7_pkg::*;
#(
  parameter int MAP_BITS     = 6,
  parameter int TEX_BITS     = 5,
  parameter int FRAC_BITS    = 16,
  parameter int H_ACTIVE     = 640,
  parameter int STRIDE_RECIP = 102,
  localparam int COORD_W     = coord_w(MAP_BITS, TEX_BITS, FRAC_BITS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_load,
  input  logic signed [COORD_W-1:0] a_u,
  input  logic signed [COORD_W-1:0] a_v,
  input  logic signed [COORD_W-1:0] b_u,
  input  logic signed [COORD_W-1:0] b_v,
  input  logic signed [COORD_W-1:0] c_u,
  input  logic signed [COORD_W-1:0] c_v,
  input  logic signed [COORD_W-1:0] d_u,
  input  logic signed [COORD_W-1:0] d_v,
  input  logic                      line_start,
  input  logic [FRAC_BITS:0]        line_weight,
  input  logic                      pix_en,
  output logic [MAP_BITS-1:0]       map_x,
  output logic [MAP_BITS-1:0]       map_y,
  output logic [TEX_BITS-1:0]       tex_x,
  output logic [TEX_BITS-1:0]       tex_y,
  output logic                      coord_valid,
  output logic                      busy,
  output logic                      outside,
  output logic                      underrun
);
  localparam int W   = COORD_W;
  localparam int PCW = $clog2(H_ACTIVE + 1);
  localparam logic [PCW-1:0] PIX_LAST = PCW'(H_ACTIVE);
  localparam int TLO = FRAC_BITS;
  localparam int MLO = FRAC_BITS + TEX_BITS;

  mode7_state_e        r_state;
  logic signed [W-1:0] w_in   [4][2];
  logic signed [W-1:0] r_sh   [4][2];
  logic signed [W-1:0] r_act  [4][2];
  logic signed [W-1:0] r_end  [4];
  logic signed [W-1:0] w_acc  [4];
  logic [3:0]          w_done;
  logic signed [W-1:0] w_stride [2];
  logic signed [W-1:0] r_stride [2];
  logic signed [W-1:0] r_pos    [2];
  logic [PCW-1:0]      r_pix;
  logic                r_valid;
  logic                r_underrun;
  logic                w_setup_phase;

  // Corner index: 0=a 1=b 2=c 3=d; axis 0=u 1=v.
  assign w_in[0][0] = a_u;  assign w_in[0][1] = a_v;
  assign w_in[1][0] = b_u;  assign w_in[1][1] = b_v;
  assign w_in[2][0] = c_u;  assign w_in[2][1] = c_v;
  assign w_in[3][0] = d_u;  assign w_in[3][1] = d_v;

  // Lanes: 0=left u, 1=left v, 2=right u, 3=right v (left a->c, right b->d).
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic signed [W-1:0] w_delta;
      assign w_delta = (r_act[gi/2][gi%2] - r_act[gi/2+2][gi%2]) >>> FRAC_BITS;
      mode7_serial_mul #(.W(W), .NBITS(FRAC_BITS + 1)) u_mul (
        .clk    (clk),
        .reset  (reset),
        .start  (line_start),
        .delta  (w_delta),
        .weight (line_weight),
        .acc    (w_acc[gi]),
        .done   (w_done[gi])
      );
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_stride
      logic signed [W-1:0] w_span;
      assign w_span       = r_end[gi+2] - r_end[gi];
      assign w_stride[gi] = W'(((2*W)'(w_span) * (2*W)'(STRIDE_RECIP)) >>> STRIDE_SHIFT);
    end
  endgenerate

  assign w_setup_phase = (r_state == ST_SETUP) || (r_state == ST_SUM) || (r_state == ST_STRIDE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pix      <= '0;
      r_valid    <= 1'b0;
      r_underrun <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        r_end[k] <= '0;
        for (int j = 0; j < 2; j++) begin
          r_sh[k][j]  <= '0;
          r_act[k][j] <= '0;
        end
      end
      for (int j = 0; j < 2; j++) begin
        r_stride[j] <= '0;
        r_pos[j]    <= '0;
      end
    end else begin
      if (frame_load) begin
        r_sh       <= w_in;
        r_underrun <= 1'b0;
      end
      if (pix_en && !line_start && w_setup_phase) r_underrun <= 1'b1;

      if (line_start) begin
        r_act   <= r_sh;
        r_valid <= 1'b0;
        r_state <= ST_SETUP;
      end else begin
        case (r_state)
          ST_SETUP: if (&w_done) r_state <= ST_SUM;
          ST_SUM: begin
            for (int k = 0; k < 4; k++) r_end[k] <= r_act[k/2+2][k%2] + w_acc[k];
            r_state <= ST_STRIDE;
          end
          ST_STRIDE: begin
            r_stride <= w_stride;
            r_state  <= ST_READY;
          end
          ST_READY: if (pix_en) begin
            r_pos[0] <= r_end[0];
            r_pos[1] <= r_end[1];
            r_pix    <= PCW'(1);
            r_valid  <= 1'b1;
            r_state  <= ST_RUN;
          end
          ST_RUN: if (pix_en) begin
            if (r_pix == PIX_LAST) begin
              r_valid <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              for (int j = 0; j < 2; j++) r_pos[j] <= r_pos[j] + r_stride[j];
              r_pix <= r_pix + 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy        = w_setup_phase;
  assign coord_valid = r_valid;
  assign underrun    = r_underrun;

`ifdef MODE7_CLAMP_EN
  // The top two bits are sign and guard: either set means off the map.
  logic w_out;
  assign w_out   = (|r_pos[0][W-1:W-2]) | (|r_pos[1][W-1:W-2]);
  assign outside = w_out;
  assign map_x   = w_out ? '0 : r_pos[0][MLO +: MAP_BITS];
  assign map_y   = w_out ? '0 : r_pos[1][MLO +: MAP_BITS];
  assign tex_x   = w_out ? '0 : r_pos[0][TLO +: TEX_BITS];
  assign tex_y   = w_out ? '0 : r_pos[1][TLO +: TEX_BITS];
`else
  assign outside = 1'b0;
  assign map_x   = r_pos[0][MLO +: MAP_BITS];
  assign map_y   = r_pos[1][MLO +: MAP_BITS];
  assign tex_x   = r_pos[0][TLO +: TEX_BITS];
  assign tex_y   = r_pos[1][TLO +: TEX_BITS];
`endif

endmodule

// File: tb/tb_mode7_span_stepper.sv
// Self-checking bench for mode7_span_stepper against a line-level arithmetic model.
module tb_mode7_span_stepper;
  localparam int W = 29;
  localparam int H = 640;
  localparam longint MASK = (longint'(1) << W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, frame_load = 1'b0, line_start = 1'b0, pix_en = 1'b0;
  logic signed [W-1:0] a_u = '0, a_v = '0, b_u = '0, b_v = '0;
  logic signed [W-1:0] c_u = '0, c_v = '0, d_u = '0, d_v = '0;
  logic [16:0] line_weight = '0;
  logic [5:0] map_x, map_y;
  logic [4:0] tex_x, tex_y;
  logic coord_valid, busy, outside, underrun;

  mode7_span_stepper dut (
    .clk(clk), .reset(reset), .frame_load(frame_load),
    .a_u(a_u), .a_v(a_v), .b_u(b_u), .b_v(b_v),
    .c_u(c_u), .c_v(c_v), .d_u(d_u), .d_v(d_v),
    .line_start(line_start), .line_weight(line_weight), .pix_en(pix_en),
    .map_x(map_x), .map_y(map_y), .tex_x(tex_x), .tex_y(tex_y),
    .coord_valid(coord_valid), .busy(busy), .outside(outside), .underrun(underrun)
  );

  int n_err = 0;
  int n_chk = 0;

  function automatic longint wrap(input longint x);
    longint m;
    m = x & MASK;
    if (m >= (longint'(1) << (W - 1))) m = m - (longint'(1) << W);
    return m;
  endfunction

  // Endpoint = bottom + ((top - bottom) >>> 16) * weight.
  function automatic longint lane(input longint top, input longint bot, input longint w);
    return wrap(bot + wrap((wrap(top - bot) >>> 16) * w));
  endfunction

  // ---------------- model: whole-line arithmetic plus a setup timeline ----------------
  longint m_sh [4][2];
  longint m_end [2][2];
  longint m_left [2], m_stride [2], m_u [2];
  int     m_setup = 0, m_n = 0;
  bit     m_ready = 0, m_run = 0, m_valid = 0, m_under = 0;
  longint um, vm;
  bit     eo;
  logic [25:0] exp_v, act_v;

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) for (int j = 0; j < 2; j++) m_sh[k][j] = 0;
      for (int j = 0; j < 2; j++) begin m_left[j] = 0; m_stride[j] = 0; m_u[j] = 0; end
      m_setup = 0; m_n = 0; m_ready = 0; m_run = 0; m_valid = 0; m_under = 0;
    end else begin
      if (frame_load) m_under = 0;
      if (line_start) begin
        for (int s = 0; s < 2; s++)
          for (int ax = 0; ax < 2; ax++)
            m_end[s][ax] = lane(m_sh[s][ax], m_sh[s+2][ax], longint'(line_weight));
        for (int ax = 0; ax < 2; ax++) begin
          m_left[ax]   = m_end[0][ax];
          m_stride[ax] = wrap((wrap(m_end[1][ax] - m_end[0][ax]) * 102) >>> 16);
        end
        m_setup = 19; m_ready = 0; m_run = 0; m_valid = 0;
      end else if (m_setup > 0) begin
        if (pix_en) m_under = 1;
        m_setup--;
        if (m_setup == 0) m_ready = 1;
      end else if (m_ready) begin
        if (pix_en) begin
          m_ready = 0; m_run = 1; m_n = 1; m_valid = 1;
          for (int ax = 0; ax < 2; ax++) m_u[ax] = m_left[ax];
        end
      end else if (m_run && pix_en) begin
        if (m_n == H) begin
          m_run = 0; m_valid = 0;
        end else begin
          m_n++;
          for (int ax = 0; ax < 2; ax++) m_u[ax] = wrap(m_left[ax] + longint'(m_n - 1) * m_stride[ax]);
        end
      end
      if (frame_load) begin
        m_sh[0][0] = a_u; m_sh[0][1] = a_v; m_sh[1][0] = b_u; m_sh[1][1] = b_v;
        m_sh[2][0] = c_u; m_sh[2][1] = c_v; m_sh[3][0] = d_u; m_sh[3][1] = d_v;
      end
    end
    #1;
    um = m_u[0] & MASK;
    vm = m_u[1] & MASK;
`ifdef MODE7_CLAMP_EN
    eo = (m_u[0] < 0) || (m_u[0] >= (longint'(1) << 27)) || (m_u[1] < 0) || (m_u[1] >= (longint'(1) << 27));
    if (eo) begin um = 0; vm = 0; end
`else
    eo = 1'b0;
`endif
    exp_v = {m_setup > 0, m_valid, m_under, eo, 6'((um >> 21) & 63), 6'((vm >> 21) & 63),
             5'((um >> 16) & 31), 5'((vm >> 16) & 31)};
    act_v = {busy, coord_valid, underrun, outside, map_x, map_y, tex_x, tex_y};
    n_chk++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL cycle t=%0t: busy/valid/under/out=%b map=%0d,%0d tex=%0d,%0d expected %b map=%0d,%0d tex=%0d,%0d",
               $time, act_v[25:22], act_v[21:16], act_v[15:10], act_v[9:5], act_v[4:0],
               exp_v[25:22], exp_v[21:16], exp_v[15:10], exp_v[9:5], exp_v[4:0]);
    end
  end

  // ---------------- stimulus helpers (all driven from negedge) ----------------
  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_corners(input longint au, input longint av, input longint bu, input longint bv,
                             input longint cu, input longint cv, input longint du, input longint dv);
    a_u = W'(au); a_v = W'(av); b_u = W'(bu); b_v = W'(bv);
    c_u = W'(cu); c_v = W'(cv); d_u = W'(du); d_v = W'(dv);
  endtask

  task automatic load_frame();
    frame_load = 1'b1; cyc(); frame_load = 1'b0;
  endtask

  task automatic start_line(input int w);
    line_weight = 17'(w); line_start = 1'b1; cyc(); line_start = 1'b0;
  endtask

  task automatic pix();
    pix_en = 1'b1; cyc(); pix_en = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (busy && n < 50) begin cyc(); n++; end
    chk("setup_done", longint'(busy), 0);
  endtask

  task automatic count_busy(output int n, input int pix_at);
    n = 0;
    while (busy && n < 50) begin
      pix_en = (n == pix_at);
      cyc();
      n++;
    end
    pix_en = 1'b0;
  endtask

  function automatic longint rnd();
    return wrap(longint'($urandom));
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dens;
    int len;
    cyc(); cyc();
    reset = 1'b0;
    chk("reset_busy", longint'(busy), 0);
    chk("reset_valid", longint'(coord_valid), 0);
    chk("reset_map_x", longint'(map_x), 0);
    chk("reset_tex_y", longint'(tex_y), 0);
    chk("reset_underrun", longint'(underrun), 0);
    $display("txn reset done");

    set_corners(13 << 21, 23 << 21, 13 << 21, 23 << 21, 13 << 21, 23 << 21, 13 << 21, 23 << 21);
    load_frame();
    start_line(32'h10000);
    count_busy(n, -1);
    chk("const_busy_len", n, 19);
    pix();
    chk("const_p1_map_x", longint'(map_x), 13);
    chk("const_p1_map_y", longint'(map_y), 23);
    chk("const_p1_tex", longint'({tex_x, tex_y}), 0);
    chk("const_p1_valid", longint'(coord_valid), 1);
    repeat (H - 1) pix();
    chk("const_p640_valid", longint'(coord_valid), 1);
    chk("const_p640_map_y", longint'(map_y), 23);
    pix();
    chk("const_valid_drop", longint'(coord_valid), 0);
    $display("txn constant-map line busy=%0d", n);

    set_corners(0, 0, 640 << 16, 0, 0, 0, 640 << 16, 0);
    load_frame();
    start_line(0);
    wait_ready();
    pix(); chk("stride_p1_tex_x", longint'(tex_x), 0);
    pix(); chk("stride_p2_tex_x", longint'(tex_x), 0);
    pix(); chk("stride_p3_tex_x", longint'(tex_x), 1);
    repeat (100) pix();
    $display("txn stride line");

    set_corners(256 << 16, 0, 0, 0, 0, 0, 0, 0);
    load_frame();
    start_line(32'h8000);
    wait_ready();
    pix();
    chk("interp_map_x", longint'(map_x), 4);
    chk("interp_tex_x", longint'(tex_x), 0);
    $display("txn interpolation line");

    start_line(32'h10000);
    repeat (4) cyc();
    start_line(32'h10000);
    count_busy(n, 3);
    chk("abort_busy_len", n, 19);
    chk("underrun_set", longint'(underrun), 1);
    load_frame();
    chk("underrun_clear", longint'(underrun), 0);
    $display("txn abort/underrun busy=%0d", n);

    set_corners(-65536, 0, -65536, 0, -65536, 0, -65536, 0);
    load_frame();
    start_line(0);
    wait_ready();
    pix();
`ifdef MODE7_CLAMP_EN
    chk("neg_outside", longint'(outside), 1);
    chk("neg_map_x", longint'(map_x), 0);
`else
    chk("neg_outside", longint'(outside), 0);
    chk("neg_map_x", longint'(map_x), 63);
    chk("neg_tex_x", longint'(tex_x), 31);
`endif
    $display("txn negative-coordinate line");

    // frame_load, line_start and pix_en together: the line keeps the old shadow.
    set_corners(7 << 21, 0, 7 << 21, 0, 7 << 21, 0, 7 << 21, 0);
    frame_load = 1'b1; line_start = 1'b1; pix_en = 1'b1; line_weight = 17'h0;
    cyc();
    frame_load = 1'b0; line_start = 1'b0; pix_en = 1'b0;
    chk("simul_no_underrun", longint'(underrun), 0);
    wait_ready();
    pix();
`ifdef MODE7_CLAMP_EN
    chk("simul_old_shadow", longint'(map_x), 0);
`else
    chk("simul_old_shadow", longint'(map_x), 63);
`endif
    start_line(0);
    wait_ready();
    pix();
    chk("simul_new_shadow", longint'(map_x), 7);
    $display("txn simultaneous frame_load/line_start");

    for (int l = 0; l < 8; l++) begin
      set_corners(rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd());
      if (l % 3 == 0) begin
        frame_load = 1'b1; cyc(); frame_load = 1'b0;
      end
      line_weight = 17'($urandom_range(0, 65536));
      line_start = 1'b1;
      frame_load = (l % 3 == 1);
      cyc();
      line_start = 1'b0; frame_load = 1'b0;
      dens = (l % 2 == 0) ? 100 : 80;
      len  = (l % 2 == 0) ? 680 : int'($urandom_range(60, 500));
      for (int c = 0; c < len; c++) begin
        pix_en = ($urandom_range(0, 99) < dens);
        if (l == 3 && c == 200) begin
          set_corners(rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd());
          frame_load = 1'b1;
        end else begin
          frame_load = 1'b0;
        end
        reset = (l == 5 && c == 250);
        cyc();
      end
      pix_en = 1'b0; frame_load = 1'b0; reset = 1'b0;
      $display("txn random line %0d weight=%0d len=%0d", l, line_weight, len);
    end

    cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mode7_span_stepper.md
# mode7_span_stepper

Parametrised per-scanline texture-coordinate generator for the Mode-7 floor renderer. Once per frame it latches the four view-frustum corners in texture space (top-left a, top-right b, bottom-left c, bottom-right d). Once per scanline it interpolates the line's left and right endpoints by a perspective weight, using a serial shift-add multiplier so no DSP blocks are needed. It then steps (u,v) once per enabled pixel and drives map/texture indices to the map and texture ROMs.

## Interface
Parameters:
- MAP_BITS, 6: map index bits per axis.
- TEX_BITS, 5: texel index bits per axis.
- FRAC_BITS, 16: fractional bits of all coordinates.
- H_ACTIVE, 640: pixels per active line.
- STRIDE_RECIP, 102: round(2^16/H_ACTIVE), the reciprocal constant for the stride.
- Derived: COORD_W = MAP_BITS+TEX_BITS+FRAC_BITS+2 (signed, one guard bit plus sign).

Ports:
- clk  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high.
- frame_load  in  1  one-cycle pulse; latch the corner inputs into the shadow set.
- a_u, a_v, b_u, b_v, c_u, c_v, d_u, d_v  in  COORD_W each  signed corner coordinates.
- line_start  in  1  one-cycle pulse; begin setup of the next line.
- line_weight  in  FRAC_BITS+1  unsigned Q1.FRAC_BITS; 2^FRAC_BITS = 1.0.
- pix_en  in  1  advance one pixel.
- map_x, map_y  out  MAP_BITS  map indices.
- tex_x, tex_y  out  TEX_BITS  texel indices.
- coord_valid  out  1  outputs hold a valid pixel coordinate.
- busy  out  1  line setup in progress.
- outside  out  1  coordinate out of map; only meaningful with MODE7_CLAMP_EN.
- underrun  out  1  sticky: pix_en arrived during setup.

## Operation
- Reset: state IDLE. All outputs, u, v, strides, and shadow/active corners are 0.
- frame_load: shadow corners <= inputs, and underrun is cleared. The active corners are copied from the shadow on each line_start. A frame_load in mid-line therefore never disturbs the current line.
- FSM states: IDLE, SETUP, SUM, STRIDE, READY, RUN.
- line_start from any state (including SETUP, SUM and STRIDE, where it aborts the current setup and restarts):
  - active corners <= shadow; weight latched; bit counter cleared; next state SETUP.
- SETUP, FRAC_BITS+1 cycles, MSB-first. Four lanes (left u/v, right u/v) each update acc <= (acc <<< 1) + (bit ? delta : 0).
  - Left deltas: (a - c) >>> FRAC_BITS. Right deltas: (b - d) >>> FRAC_BITS.
  - All shifts are arithmetic.
- SUM: left = c + acc_left, right = d + acc_right.
- STRIDE: stride_u = ((right_u - left_u) * STRIDE_RECIP) >>> 16, and likewise for v. Result is truncated toward minus infinity and kept at COORD_W bits. Next state READY.
- pix_en in READY: u,v <= left; pixel counter = 1; next state RUN.
- pix_en in RUN with counter < H_ACTIVE: u <= u + stride_u, v <= v + stride_v; counter increments.
- pix_en in RUN with counter = H_ACTIVE: ignored; coord_valid drops to 0; next state IDLE.
- pix_en in SETUP, SUM or STRIDE: ignored, and underrun <= 1. pix_en in IDLE: ignored.
- Output slicing:
  - map_x = u[FRAC_BITS+TEX_BITS+MAP_BITS-1 : FRAC_BITS+TEX_BITS]
  - tex_x = u[FRAC_BITS+TEX_BITS-1 : FRAC_BITS]
  - map_y and tex_y come from v in the same way.
- All arithmetic is two's-complement at COORD_W bits. Overflow wraps silently.

## Timing
- Line setup latency: busy rises on the cycle after line_start and stays high for FRAC_BITS+3 cycles (19 by default). It falls on entry to READY.
- Pixel latency: indices and coord_valid update on the same edge that samples pix_en, so they are registered with 1-cycle latency to the ROM address.
- coord_valid is 1 from the first accepted pix_en until the H_ACTIVE-th pixel has been held. It is 0 after a line_start.
- Simultaneous line_start and pix_en: line_start wins and the pix_en is dropped; underrun is not set.
- Simultaneous frame_load and line_start: the new inputs reach the shadow only. The line uses the previous shadow.
- Reset mid-setup or mid-line returns to the reset state on the next edge.

## Configuration
- MODE7_CLAMP_EN defined:
  - A coordinate is outside when u < 0, v < 0, u >= 2^(MAP_BITS+TEX_BITS+FRAC_BITS), or v >= 2^(MAP_BITS+TEX_BITS+FRAC_BITS).
  - When outside, outside = 1 and map_x, map_y, tex_x, tex_y are forced to 0.
- MODE7_CLAMP_EN undefined: outside is tied to 0 and the indices wrap modulo the map size (toroidal map).

## Structure
- Package mode7_pkg holds the FSM state enum, the COORD_W calculation function, and the STRIDE shift constant (16).
- Sub-module mode7_serial_mul is one shift-add lane. It takes start, delta and weight, and produces acc and done. The block instantiates it four times.

## Test plan
- Reset: assert reset for 2 cycles → all outputs 0, state IDLE, busy 0, coord_valid 0.
- Constant map:
  - Stimulus: all corners u = 13<<21, v = 23<<21; weight 0x10000; line_start.
  - Required: busy stays high for exactly 19 cycles.
  - Then 640 pix_en → map_x = 13, map_y = 23, tex = 0 on every pixel; coord_valid falls after pixel 640.
- Stride:
  - Stimulus: c_u = 0, d_u = 640<<16, a = c, b = d, weight 0.
  - Required: stride_u = 65280; pixel 1 tex_x = 0, pixel 2 tex_x = 0, pixel 3 (u = 130560) tex_x = 1.
- Interpolation:
  - Stimulus: a_u - c_u = 256<<16, c_u = 0, weight 0x8000.
  - Required: left_u = 128<<16, so pixel 1 gives map_x = 4, tex_x = 0.
- Aborts and underrun:
  - A second line_start 5 cycles into SETUP → busy lasts 19 cycles from the second pulse.
  - pix_en during that setup → underrun = 1. A following frame_load clears it.
- Configuration:
  - Stimulus: c_u = d_u = -1<<16.
  - With MODE7_CLAMP_EN: outside = 1, map_x = 0.
  - Without MODE7_CLAMP_EN: map_x = 63, tex_x = 31.
